// File: rtl/shift_mult_ctrl.sv
// shift_mult_ctrl: sequential shift-and-add unsigned multiplier with a
// valid/ready operand port, valid/ready result port, abort and an overflow
// flag for products that do not fit in WIDTH bits.
module shift_mult_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] P,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] q;
   logic             ovf_r;

   // Step datapath: the add keeps its carry so a lost product bit can be flagged.
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] m_shift;
   logic [WIDTH-1:0] q_shift;
   logic             step_ovf;

   // One multiply step computed from the current registers.
   always_comb begin
      sum_w    = {1'b0, acc} + {1'b0, m};
      m_shift  = {m[WIDTH-2:0], 1'b0};
      q_shift  = {1'b0, q[WIDTH-1:1]};
      // A set multiplicand MSB about to be shifted out matters only if more
      // multiplier bits remain to be added.
      step_ovf = (q[0] & sum_w[WIDTH]) | (m[WIDTH-1] & (q_shift != '0));
   end

   // Handshake outputs decode straight from the state register.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign P         = acc;
   assign ovf       = ovf_r;

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         m     <= '0;
         q     <= '0;
         ovf_r <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; step_ovf and sum_w rely on the old m/q/acc.
         case (state)
            IDLE: begin
               // abort is deliberately ignored here.
               if (in_valid) begin
                  m     <= A;
                  q     <= B;
                  acc   <= '0;
                  ovf_r <= 1'b0;
                  state <= (B == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  if (q[0]) acc <= sum_w[WIDTH-1:0];
                  m <= m_shift;
                  q <= q_shift;
                  if (step_ovf) ovf_r <= 1'b1;
                  if (q_shift == '0) state <= DONE;
               end
            end
            DONE: begin
               if (abort || out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
